// File: rtl/datapath_control_unit_if.sv
// Strobe bundle between the control sequencer and the single-bus datapath.
// The sequencer (master) consumes Run/IR and drives every control strobe.
interface datapath_control_unit_if #(
  parameter int NREGS = 16
);
  logic             Run;
  logic [31:0]      IR;
  logic             PCout;
  logic             MARin;
  logic             IncPC;
  logic             Zin;
  logic             PCin;
  logic             Read;
  logic             MDRin;
  logic             MDRout;
  logic             IRin;
  logic             Yin;
  logic             Zhiout;
  logic             Zloout;
  logic             HIin;
  logic             LOin;
  logic [NREGS-1:0] Rin;
  logic [NREGS-1:0] Rout;
  logic [3:0]       ALUControl;
  logic             Busy;
  logic             Halted;
  logic [3:0]       State;

  modport master (
    input  Run, IR,
    output PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
           Zhiout, Zloout, HIin, LOin, Rin, Rout, ALUControl, Busy, Halted, State
  );

  modport slave (
    output Run, IR,
    input  PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
           Zhiout, Zloout, HIin, LOin, Rin, Rout, ALUControl, Busy, Halted, State
  );
endinterface

// File: rtl/datapath_control_unit.sv
// Moore control sequencer: fetch (T0-T2) and execute (T3-T6) strobes for the
// single-bus datapath, with IR decode into one-hot register selects and ALU op.
module datapath_control_unit #(
  parameter int NREGS = 16
) (
  input  logic                    Clock,
  input  logic                    GlobalReset,
  datapath_control_unit_if.master ctrl
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_HALTED = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU3   = 3'd0,
    CLS_MULDIV = 3'd1,
    CLS_UNARY  = 3'd2,
    CLS_NOP    = 3'd3,
    CLS_HALT   = 3'd4
  } class_e;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic zhi_out;
    logic zlo_out;
    logic hi_in;
    logic lo_in;
  } strobes_t;

  state_e           state_q;
  state_e           state_d;
  state_e           instr_end_s;
  class_e           cls_s;
  logic [4:0]       opcode_s;
  logic [3:0]       ra_s;
  logic [3:0]       rb_s;
  logic [3:0]       rc_s;
  strobes_t         strb_s;
  logic [NREGS-1:0] rin_s;
  logic [NREGS-1:0] rout_s;
  logic [3:0]       alu_s;
  logic             busy_s;
  logic             halted_s;
  logic             unused_ir_s;

  // Unknown opcodes fall into the nop class so they still end cleanly at T3.
  function automatic class_e decode_class(logic [4:0] op);
    class_e c;
    if (op[4:3] == 2'b00) begin
      c = CLS_ALU3;
    end else if ((op == 5'b01000) || (op == 5'b01001)) begin
      c = CLS_MULDIV;
    end else if ((op == 5'b01010) || (op == 5'b01011)) begin
      c = CLS_UNARY;
    end else if (op == 5'b11011) begin
      c = CLS_HALT;
    end else begin
      c = CLS_NOP;
    end
    return c;
  endfunction

  function automatic logic [NREGS-1:0] reg_sel(logic [3:0] idx);
    logic [NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) begin
      if (int'(idx) == i) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  assign opcode_s    = ctrl.IR[31:27];
  assign ra_s        = ctrl.IR[26:23];
  assign rb_s        = ctrl.IR[22:19];
  assign rc_s        = ctrl.IR[18:15];
  assign cls_s       = decode_class(opcode_s);
  assign unused_ir_s = ^ctrl.IR[14:0];
  assign instr_end_s = ctrl.Run ? S_T0 : S_IDLE;

  // State register.
  always_ff @(posedge Clock) begin
    if (GlobalReset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; Run only matters in IDLE and at an instruction end.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl.Run) begin
          state_d = S_T0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T0: state_d = S_T1;
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: begin
        case (cls_s)
          CLS_HALT: state_d = S_HALTED;
          CLS_NOP:  state_d = instr_end_s;
          default:  state_d = S_T4;
        endcase
      end
      S_T4: begin
        case (cls_s)
          CLS_ALU3, CLS_MULDIV: state_d = S_T5;
          default:              state_d = instr_end_s;
        endcase
      end
      S_T5: begin
        case (cls_s)
          CLS_MULDIV: state_d = S_T6;
          default:    state_d = instr_end_s;
        endcase
      end
      S_T6:     state_d = instr_end_s;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Per-step strobes, decoded from the state register and IR only.
  always_comb begin
    strb_s = '0;
    rin_s  = '0;
    rout_s = '0;
    alu_s  = 4'd0;
    case (state_q)
      S_T0: begin
        strb_s.pc_out = 1'b1;
        strb_s.mar_in = 1'b1;
        strb_s.inc_pc = 1'b1;
        strb_s.z_in   = 1'b1;
      end
      S_T1: begin
        strb_s.zlo_out = 1'b1;
        strb_s.pc_in   = 1'b1;
        strb_s.read    = 1'b1;
        strb_s.mdr_in  = 1'b1;
      end
      S_T2: begin
        strb_s.mdr_out = 1'b1;
        strb_s.ir_in   = 1'b1;
      end
      S_T3: begin
        case (cls_s)
          CLS_ALU3: begin
            rout_s      = reg_sel(rb_s);
            strb_s.y_in = 1'b1;
          end
          CLS_MULDIV: begin
            rout_s      = reg_sel(ra_s);
            strb_s.y_in = 1'b1;
          end
          CLS_UNARY: begin
            rout_s      = reg_sel(rb_s);
            alu_s       = opcode_s[3:0];
            strb_s.z_in = 1'b1;
          end
          default: strb_s = '0;
        endcase
      end
      S_T4: begin
        case (cls_s)
          CLS_ALU3: begin
            rout_s      = reg_sel(rc_s);
            alu_s       = opcode_s[3:0];
            strb_s.z_in = 1'b1;
          end
          CLS_MULDIV: begin
            rout_s      = reg_sel(rb_s);
            alu_s       = opcode_s[3:0];
            strb_s.z_in = 1'b1;
          end
          CLS_UNARY: begin
            strb_s.zlo_out = 1'b1;
            rin_s          = reg_sel(ra_s);
          end
          default: strb_s = '0;
        endcase
      end
      S_T5: begin
        case (cls_s)
          CLS_ALU3: begin
            strb_s.zlo_out = 1'b1;
            rin_s          = reg_sel(ra_s);
          end
          CLS_MULDIV: begin
            strb_s.zlo_out = 1'b1;
            strb_s.lo_in   = 1'b1;
          end
          default: strb_s = '0;
        endcase
      end
      S_T6: begin
        case (cls_s)
          CLS_MULDIV: begin
            strb_s.zhi_out = 1'b1;
            strb_s.hi_in   = 1'b1;
          end
          default: strb_s = '0;
        endcase
      end
      default: strb_s = '0;
    endcase
  end

  assign busy_s   = (state_q >= S_T0) && (state_q <= S_T6);
  assign halted_s = (state_q == S_HALTED);

  // Reset masks every output so nothing is latched by the datapath that cycle.
  always_comb begin
    if (GlobalReset) begin
      {ctrl.PCout, ctrl.MARin, ctrl.IncPC, ctrl.Zin, ctrl.PCin, ctrl.Read,
       ctrl.MDRin, ctrl.MDRout, ctrl.IRin, ctrl.Yin, ctrl.Zhiout, ctrl.Zloout,
       ctrl.HIin, ctrl.LOin} = 14'd0;
      ctrl.Rin        = '0;
      ctrl.Rout       = '0;
      ctrl.ALUControl = 4'd0;
      ctrl.Busy       = 1'b0;
      ctrl.Halted     = 1'b0;
      ctrl.State      = 4'd0;
    end else begin
      {ctrl.PCout, ctrl.MARin, ctrl.IncPC, ctrl.Zin, ctrl.PCin, ctrl.Read,
       ctrl.MDRin, ctrl.MDRout, ctrl.IRin, ctrl.Yin, ctrl.Zhiout, ctrl.Zloout,
       ctrl.HIin, ctrl.LOin} = strb_s;
      ctrl.Rin        = rin_s;
      ctrl.Rout       = rout_s;
      ctrl.ALUControl = alu_s;
      ctrl.Busy       = busy_s;
      ctrl.Halted     = halted_s;
      ctrl.State      = state_q;
    end
  end

endmodule

// File: tb/tb_datapath_control_unit.sv
// Directed bench for datapath_control_unit: per-step strobe vectors for each
// instruction class, halt, Run drop and reset behaviour.
module tb_datapath_control_unit;

  // Strobe order: PCout MARin IncPC Zin PCin Read MDRin MDRout IRin Yin Zhiout Zloout HIin LOin
  localparam logic [13:0] F0  = 14'h3C00;
  localparam logic [13:0] F1  = 14'h0384;
  localparam logic [13:0] F2  = 14'h0060;
  localparam logic [13:0] YIN = 14'h0010;
  localparam logic [13:0] ZIN = 14'h0400;
  localparam logic [13:0] ZLO = 14'h0004;
  localparam logic [13:0] ZHI = 14'h0008;
  localparam logic [13:0] HIN = 14'h0002;
  localparam logic [13:0] LON = 14'h0001;

  logic Clock;
  logic GlobalReset;
  int   vectors;
  int   miscompares;

  datapath_control_unit_if #(.NREGS(16)) ifc ();

  datapath_control_unit #(.NREGS(16)) dut (
    .Clock      (Clock),
    .GlobalReset(GlobalReset),
    .ctrl       (ifc)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [55:0] obs();
    return {ifc.PCout, ifc.MARin, ifc.IncPC, ifc.Zin, ifc.PCin, ifc.Read, ifc.MDRin,
            ifc.MDRout, ifc.IRin, ifc.Yin, ifc.Zhiout, ifc.Zloout, ifc.HIin, ifc.LOin,
            ifc.Rin, ifc.Rout, ifc.ALUControl, ifc.Busy, ifc.Halted, ifc.State};
  endfunction

  function automatic logic [55:0] ex(logic [13:0] s, logic [15:0] ri, logic [15:0] ro,
                                     logic [3:0] alu, logic busy, logic halted,
                                     logic [3:0] st);
    return {s, ri, ro, alu, busy, halted, st};
  endfunction

  task automatic cyc();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic do_reset();
    GlobalReset = 1'b1;
    ifc.Run     = 1'b0;
    cyc();
    cyc();
    GlobalReset = 1'b0;
  endtask

  task automatic test_reset();
    GlobalReset = 1'b1;
    ifc.Run     = 1'b1;
    ifc.IR      = 32'h011A0000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++;
      if (obs() !== 56'd0) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs(), 56'd0);
      end
    end
    GlobalReset = 1'b0;
    vectors++;
    if (obs() !== 56'd0) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", obs(), 56'd0);
    end
    cyc();
    vectors++;
    if (obs() !== ex(F0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 4'd1)) begin
      miscompares++;
      $display("FAIL reset_then_t0: got %h expected %h", obs(),
               ex(F0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 4'd1));
    end
  endtask

  task automatic test_add();
    logic [55:0] exp_v [7];
    exp_v[0] = ex(F0,  16'h0,    16'h0,    4'h0, 1'b1, 1'b0, 4'd1);
    exp_v[1] = ex(F1,  16'h0,    16'h0,    4'h0, 1'b1, 1'b0, 4'd2);
    exp_v[2] = ex(F2,  16'h0,    16'h0,    4'h0, 1'b1, 1'b0, 4'd3);
    exp_v[3] = ex(YIN, 16'h0,    16'h0008, 4'h0, 1'b1, 1'b0, 4'd4);
    exp_v[4] = ex(ZIN, 16'h0,    16'h0010, 4'h0, 1'b1, 1'b0, 4'd5);
    exp_v[5] = ex(ZLO, 16'h0004, 16'h0,    4'h0, 1'b1, 1'b0, 4'd6);
    exp_v[6] = ex(F0,  16'h0,    16'h0,    4'h0, 1'b1, 1'b0, 4'd1);
    do_reset();
    ifc.IR  = 32'h011A0000;
    ifc.Run = 1'b1;
    cyc();
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (obs() !== exp_v[i]) begin
        miscompares++;
        $display("FAIL add step %0d: got %h expected %h", i, obs(), exp_v[i]);
      end
      cyc();
    end
  endtask

  task automatic test_mul();
    logic [55:0] exp_v [8];
    exp_v[0] = ex(F0,        16'h0, 16'h0,    4'h0, 1'b1, 1'b0, 4'd1);
    exp_v[1] = ex(F1,        16'h0, 16'h0,    4'h0, 1'b1, 1'b0, 4'd2);
    exp_v[2] = ex(F2,        16'h0, 16'h0,    4'h0, 1'b1, 1'b0, 4'd3);
    exp_v[3] = ex(YIN,       16'h0, 16'h0020, 4'h0, 1'b1, 1'b0, 4'd4);
    exp_v[4] = ex(ZIN,       16'h0, 16'h0040, 4'h8, 1'b1, 1'b0, 4'd5);
    exp_v[5] = ex(ZLO | LON, 16'h0, 16'h0,    4'h0, 1'b1, 1'b0, 4'd6);
    exp_v[6] = ex(ZHI | HIN, 16'h0, 16'h0,    4'h0, 1'b1, 1'b0, 4'd7);
    exp_v[7] = ex(14'h0,     16'h0, 16'h0,    4'h0, 1'b0, 1'b0, 4'd0);
    do_reset();
    ifc.IR  = 32'h42B00000;
    ifc.Run = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (obs() !== exp_v[i]) begin
        miscompares++;
        $display("FAIL mul step %0d: got %h expected %h", i, obs(), exp_v[i]);
      end
      if (i == 6) ifc.Run = 1'b0;
      cyc();
    end
  endtask

  task automatic test_not();
    logic [55:0] exp_v [6];
    exp_v[0] = ex(F0,  16'h0,    16'h0,    4'h0, 1'b1, 1'b0, 4'd1);
    exp_v[1] = ex(F1,  16'h0,    16'h0,    4'h0, 1'b1, 1'b0, 4'd2);
    exp_v[2] = ex(F2,  16'h0,    16'h0,    4'h0, 1'b1, 1'b0, 4'd3);
    exp_v[3] = ex(ZIN, 16'h0,    16'h0080, 4'hB, 1'b1, 1'b0, 4'd4);
    exp_v[4] = ex(ZLO, 16'h0002, 16'h0,    4'h0, 1'b1, 1'b0, 4'd5);
    exp_v[5] = ex(F0,  16'h0,    16'h0,    4'h0, 1'b1, 1'b0, 4'd1);
    do_reset();
    ifc.IR  = 32'h58B80000;
    ifc.Run = 1'b1;
    cyc();
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (obs() !== exp_v[i]) begin
        miscompares++;
        $display("FAIL not step %0d: got %h expected %h", i, obs(), exp_v[i]);
      end
      cyc();
    end
  endtask

  task automatic test_nop();
    logic [31:0] irs [2];
    irs[0] = 32'hD0000000;
    irs[1] = 32'h78000000;
    for (int n = 0; n < 2; n++) begin
      do_reset();
      ifc.IR  = irs[n];
      ifc.Run = 1'b1;
      cyc();
      repeat (3) cyc();
      vectors++;
      if (obs() !== ex(14'h0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 4'd4)) begin
        miscompares++;
        $display("FAIL nop_t3 ir=%h: got %h expected %h", irs[n], obs(),
                 ex(14'h0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 4'd4));
      end
      cyc();
      vectors++;
      if (obs() !== ex(F0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 4'd1)) begin
        miscompares++;
        $display("FAIL nop_next ir=%h: got %h expected %h", irs[n], obs(),
                 ex(F0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 4'd1));
      end
    end
  endtask

  task automatic test_alu_codes();
    logic [4:0]  opc;
    logic [15:0] er;
    int          k;
    int          len;
    for (int op = 0; op < 12; op++) begin
      opc = 5'(op);
      k   = (op >= 10) ? 3 : 4;
      len = (op < 8) ? 6 : ((op < 10) ? 7 : 5);
      er  = (op < 8) ? 16'h0008 : 16'h0004;
      do_reset();
      ifc.IR  = {opc, 4'd1, 4'd2, 4'd3, 15'd0};
      ifc.Run = 1'b1;
      cyc();
      repeat (k) cyc();
      vectors++;
      if ({ifc.ALUControl, ifc.Rout, ifc.Zin} !== {opc[3:0], er, 1'b1}) begin
        miscompares++;
        $display("FAIL alu_step op=%0d: got alu=%h rout=%h zin=%b expected alu=%h rout=%h zin=1",
                 op, ifc.ALUControl, ifc.Rout, ifc.Zin, opc[3:0], er);
      end
      repeat (len - k) cyc();
      vectors++;
      if (ifc.State !== 4'd1) begin
        miscompares++;
        $display("FAIL alu_len op=%0d: got state %0d expected 1 after %0d cycles",
                 op, ifc.State, len);
      end
    end
  endtask

  task automatic test_halt();
    int bad;
    do_reset();
    ifc.IR  = 32'hD8000000;
    ifc.Run = 1'b1;
    cyc();
    repeat (3) cyc();
    vectors++;
    if (obs() !== ex(14'h0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 4'd4)) begin
      miscompares++;
      $display("FAIL halt_t3: got %h expected %h", obs(),
               ex(14'h0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 4'd4));
    end
    cyc();
    vectors++;
    if (obs() !== ex(14'h0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b1, 4'd8)) begin
      miscompares++;
      $display("FAIL halt_enter: got %h expected %h", obs(),
               ex(14'h0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b1, 4'd8));
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if ((ifc.PCout !== 1'b0) || (ifc.State !== 4'd8) || (ifc.Halted !== 1'b1)) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL halt_stay: got %0d bad cycles expected 0", bad);
    end
    GlobalReset = 1'b1;
    cyc();
    GlobalReset = 1'b0;
    ifc.Run     = 1'b0;
    vectors++;
    if (obs() !== 56'd0) begin
      miscompares++;
      $display("FAIL halt_reset: got %h expected %h", obs(), 56'd0);
    end
  endtask

  task automatic test_run_drop();
    do_reset();
    ifc.IR  = 32'h011A0000;
    ifc.Run = 1'b1;
    cyc();
    repeat (4) cyc();
    ifc.Run = 1'b0;
    cyc();
    vectors++;
    if (obs() !== ex(ZLO, 16'h0004, 16'h0, 4'h0, 1'b1, 1'b0, 4'd6)) begin
      miscompares++;
      $display("FAIL run_drop_t5: got %h expected %h", obs(),
               ex(ZLO, 16'h0004, 16'h0, 4'h0, 1'b1, 1'b0, 4'd6));
    end
    cyc();
    cyc();
    vectors++;
    if (obs() !== 56'd0) begin
      miscompares++;
      $display("FAIL run_drop_idle: got %h expected %h", obs(), 56'd0);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lohi;
    do_reset();
    ifc.IR  = 32'h42B00000;
    ifc.Run = 1'b1;
    cyc();
    repeat (4) cyc();
    vectors++;
    if (ifc.State !== 4'd5) begin
      miscompares++;
      $display("FAIL mid_mul_t4: got state %0d expected 5", ifc.State);
    end
    GlobalReset = 1'b1;
    #1;
    vectors++;
    if (obs() !== 56'd0) begin
      miscompares++;
      $display("FAIL mid_mul_reset_cycle: got %h expected %h", obs(), 56'd0);
    end
    cyc();
    GlobalReset = 1'b0;
    ifc.Run     = 1'b0;
    vectors++;
    if (obs() !== 56'd0) begin
      miscompares++;
      $display("FAIL mid_mul_after: got %h expected %h", obs(), 56'd0);
    end
    lohi = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if ((ifc.LOin !== 1'b0) || (ifc.HIin !== 1'b0) || (ifc.State !== 4'd0)) lohi++;
    end
    vectors++;
    if (lohi !== 0) begin
      miscompares++;
      $display("FAIL mid_mul_no_lohi: got %0d bad cycles expected 0", lohi);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    GlobalReset = 1'b1;
    ifc.Run     = 1'b0;
    ifc.IR      = 32'h0;
    @(negedge Clock);
    test_reset();
    test_add();
    test_mul();
    test_not();
    test_nop();
    test_alu_codes();
    test_halt();
    test_run_drop();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/datapath_control_unit.md
# datapath_control_unit

Moore-style control sequencer for the single-bus datapath. It drives the per-step control strobes for fetch (T0–T2) and execute (T3–T6), and decodes the 32-bit IR into one-hot register-select strobes and an ALU operation code. It sits beside the datapath, takes IR back from it, and replaces hand-sequenced testbench stimulus.

## Interface
Parameters:
- NREGS, 16, number of general registers (one-hot width of Rin/Rout)

Ports:
- Clock  in  1  system clock; all state changes on rising edge
- GlobalReset  in  1  reset, synchronous and active-high
- Run  in  1  level; 1 = fetch/execute instructions, 0 = stop at next instruction boundary
- IR  in  32  instruction register contents from the datapath
- PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin, Zhiout, Zloout, HIin, LOin  out  1 each  datapath strobes
- Rin  out  NREGS  one-hot register load
- Rout  out  NREGS  one-hot register drive onto bus
- ALUControl  out  4  ALU operation
- Busy  out  1  high in T0–T6
- Halted  out  1  high in HALTED
- State  out  4  current state encoding, for debug

## Operation
IR fields:
- opcode = IR[31:27]
- Ra = IR[26:23]
- Rb = IR[22:19]
- Rc = IR[18:15]

Opcodes and their ALUControl codes:
- add 00000 → 0000
- sub 00001 → 0001
- and 00010 → 0010
- or 00011 → 0011
- shr 00100 → 0100
- shl 00101 → 0101
- ror 00110 → 0110
- rol 00111 → 0111
- mul 01000 → 1000
- div 01001 → 1001
- neg 01010 → 1010
- not 01011 → 1011
- nop 11010 (no ALU code)
- halt 11011 (no ALU code)
- Any other opcode executes as nop.

States and encoding: IDLE=0, T0=1 … T6=7, HALTED=8.

- **IDLE:** all strobes 0. Go to T0 when Run=1.
- **T0:** PCout, MARin, IncPC, Zin.
- **T1:** Zloout, PCin, Read, MDRin.
- **T2:** MDRout, IRin. IR is valid from T3 onward.
- **T3 (decode):**
  - 3-operand ALU ops (add..rol): Rout[Rb], Yin.
  - mul/div: Rout[Ra], Yin.
  - neg/not: Rout[Rb], ALUControl=op, Zin.
  - nop: no strobes; instruction ends.
  - halt: no strobes; next state HALTED.
- **T4:**
  - 3-operand: Rout[Rc], ALUControl=op, Zin.
  - mul/div: Rout[Rb], ALUControl=op, Zin.
  - neg/not: Zloout, Rin[Ra]; instruction ends.
- **T5:**
  - 3-operand: Zloout, Rin[Ra]; instruction ends.
  - mul/div: Zloout, LOin.
- **T6 (mul/div only):** Zhiout, HIin; instruction ends.
- **Instruction end:** next state is T0 if Run=1, otherwise IDLE.
- **HALTED:** all strobes 0, Halted=1. Leaves only on reset; Run is ignored.
- **Output defaults:** ALUControl=0000 and Rin/Rout=0 in every step not listed above. At most one bit of Rin and at most one bit of Rout is set in any cycle.
- **Bus exclusivity:** in any cycle at most one of PCout, MDRout, Zhiout, Zloout, or any Rout bit is high.

## Timing
- **Outputs:** pure functions of the state register and IR. Each strobe is high for exactly one full clock in its step; the datapath captures on the rising edge that ends the step.
- **Instruction length:** nop = 4 cycles (T0–T3); neg/not = 5; 3-operand = 6; mul/div = 7; halt reaches HALTED after 4 cycles.
- **Run:** sampled only in IDLE and at instruction end. Deasserting Run mid-instruction does not abort the instruction.
- **Reset:** GlobalReset high at a rising edge sets state to IDLE, from any state including mid-instruction and HALTED. While GlobalReset is high, all strobes, Rin, Rout, and ALUControl are forced to 0 combinationally, so no register write occurs in the reset cycle.
- **Reset values:** every output is 0 and State=0000.
- **Reset and Run together:** reset wins; T0 is entered at the earliest on the first edge after GlobalReset falls with Run=1.

## Test plan
- **add R2,R3,R4 (IR=0x011A0000), Run=1 →**
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zloout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - T3: Rout=0x0008, Yin.
  - T4: Rout=0x0010, ALUControl=0000, Zin.
  - T5: Zloout, Rin=0x0004.
  - Next cycle is T0 again.
- **mul R5,R6 (IR=0x42B00000) →**
  - T3: Rout=0x0020, Yin.
  - T4: Rout=0x0040, ALUControl=1000, Zin.
  - T5: Zloout, LOin.
  - T6: Zhiout, HIin.
  - 7 cycles total.
- **not R1,R7 (IR=0x58B80000) →**
  - T3: Rout=0x0080, ALUControl=1011, Zin.
  - T4: Zloout, Rin=0x0002.
  - 5 cycles total.
- **halt (IR=0xD8000000) →**
  - State=8 and Halted=1 after T3.
  - No PCout for 20 further cycles with Run=1.
  - GlobalReset pulse returns State to 0.
- **Run dropped during T4 of add →**
  - T5 still completes with Rin=0x0004.
  - Then IDLE; Busy=0.
- **GlobalReset asserted during T4 of mul →**
  - All outputs are 0 in that cycle.
  - State=0 after the edge.
  - LOin and HIin are never asserted.
